// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared types for the MEM->WB elastic stage: register-file widths, write-back
// payload layout and the occupancy states of the two-slot buffer.
package mem_wb_pipe_stage_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r;
    logic [REG_DATA_W-1:0] alu_res;
    logic [REG_DATA_W-1:0] mem_res;
    logic [REG_ADDR_W-1:0] dest;
  } wb_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_t;

  function automatic slot_state_t decode_state(input logic main_v, input logic skid_v);
    if (main_v && skid_v) return ST_FULL;
    else if (main_v)      return ST_HALF;
    else                  return ST_EMPTY;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_stage_stage_slot.sv
// One buffer entry of the MEM->WB stage: payload register plus valid bit.
// clear wins over load; clearing leaves the payload as it was.
module stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB elastic stage: main slot drives WB, skid slot absorbs one item so that
// in_ready never depends combinationally on out_ready. Optional stall counter
// output stall_cnt is built when MEM_WB_STALL_CNT_EN is defined.
module mem_wb_pipe_stage
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
`ifdef MEM_WB_STALL_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_res,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_mem_res,
  output logic [ADDR_W-1:0] out_dest
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int PLD_W = 2 + 2 * DATA_W + ADDR_W;

  logic [PLD_W-1:0] in_pld_p0;
  logic [PLD_W-1:0] main_d_p0;
  logic [PLD_W-1:0] main_pld_p1;
  logic [PLD_W-1:0] skid_pld_p1;
  logic             main_vld_p1;
  logic             skid_vld_p1;
  logic             main_wb_en_p1;
  logic             acc;
  logic             pop;
  logic             main_load;
  logic             main_clear;
  logic             main_from_skid;
  logic             skid_load;
  logic             skid_clear;
  slot_state_t      state;

  assign in_pld_p0 = {in_wb_en, in_mem_r, in_alu_res, in_mem_res, in_dest};

  assign in_ready = ~skid_vld_p1 & ~freeze & ~flush & rst;
  assign acc      = in_valid & in_ready;
  assign pop      = main_vld_p1 & out_ready & ~freeze;
  assign state    = decode_state(main_vld_p1, skid_vld_p1);

  // Freeze needs no term here: acc and pop are both forced low by it.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = acc;
        ST_HALF: begin
          if (acc && pop)  main_load  = 1'b1;
          else if (acc)    skid_load  = 1'b1;
          else if (pop)    main_clear = 1'b1;
        end
        ST_FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_d_p0 = main_from_skid ? skid_pld_p1 : in_pld_p0;

  // ---- p0 -> p1: slot registers ----
  stage_slot #(.W(PLD_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d_p0),
    .q     (main_pld_p1),
    .vld   (main_vld_p1)
  );

  stage_slot #(.W(PLD_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pld_p0),
    .q     (skid_pld_p1),
    .vld   (skid_vld_p1)
  );

  assign {main_wb_en_p1, out_mem_r, out_alu_res, out_mem_res, out_dest} = main_pld_p1;
  assign out_valid = main_vld_p1;
  assign out_wb_en = main_wb_en_p1 & main_vld_p1;

`ifdef MEM_WB_STALL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_vld_p1 && !out_ready && !freeze) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: directed scenarios plus a scoreboard that checks
// every item WB consumes. Build with MEM_WB_STALL_CNT_EN to cover the stall counter.
module tb_mem_wb_pipe_stage;
  import mem_wb_pipe_stage_pkg::*;

  localparam int DATA_W = REG_DATA_W;
  localparam int ADDR_W = REG_ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze, flush;
  logic              in_valid, in_ready, in_wb_en, in_mem_r;
  logic [DATA_W-1:0] in_alu_res, in_mem_res;
  logic [ADDR_W-1:0] in_dest;
  logic              out_valid, out_ready, out_wb_en, out_mem_r;
  logic [DATA_W-1:0] out_alu_res, out_mem_res;
  logic [ADDR_W-1:0] out_dest;
`ifdef MEM_WB_STALL_CNT_EN
  logic [1:0]        stall_cnt;
`endif

  int total, bad, sb_total, sb_bad;
  wb_payload_t exp_q[$];
  wb_payload_t in_pld, obs_pld;

  assign in_pld  = wb_payload_t'({in_wb_en, in_mem_r, in_alu_res, in_mem_res, in_dest});
  assign obs_pld = wb_payload_t'({out_wb_en, out_mem_r, out_alu_res, out_mem_res, out_dest});

  always #5 clk = ~clk;

  mem_wb_pipe_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wb_en    (in_wb_en),
    .in_mem_r    (in_mem_r),
    .in_alu_res  (in_alu_res),
    .in_mem_res  (in_mem_res),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wb_en   (out_wb_en),
    .out_mem_r   (out_mem_r),
    .out_alu_res (out_alu_res),
    .out_mem_res (out_mem_res),
    .out_dest    (out_dest)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Scoreboard: push on acceptance, pop and compare on WB consumption, drop on flush/reset.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && !freeze) begin
        sb_total <= sb_total + 1;
        if (exp_q.size() == 0) begin
          sb_bad <= sb_bad + 1;
          $display("FAIL sb_unexpected_item: got dest=%0h want no item", out_dest);
        end else begin
          if (obs_pld !== exp_q[0]) begin
            sb_bad <= sb_bad + 1;
            $display("FAIL sb_payload: got %h want %h", obs_pld, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_pld);
      if (flush) exp_q.delete();
    end
  end

  task automatic drive_item(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] alu,
                            input logic [DATA_W-1:0] mem, input logic wb, input logic mr);
    in_valid = 1'b1; in_dest = d; in_alu_res = alu; in_mem_res = mem;
    in_wb_en = wb; in_mem_r = mr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive_item(4'h6, 32'h1234, 32'h5678, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_wb_en !== 1'b0) begin bad++; $display("FAIL rst_out_wb_en: got %b want 0", out_wb_en); end
    total++; if ({out_mem_r, out_alu_res, out_mem_res, out_dest} !== '0) begin
      bad++; $display("FAIL rst_payload: got %h want 0", {out_mem_r, out_alu_res, out_mem_res, out_dest}); end
    @(posedge clk); #1; rst = 1'b1; idle();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      drive_item(ADDR_W'(i), DATA_W'(32'h100 + i), DATA_W'(i * 7), 1'b1, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 1) begin
        total++; if (out_valid !== 1'b1 || out_dest !== ADDR_W'(i - 1)) begin
          bad++; $display("FAIL stream_dest[%0d]: got v=%b d=%0h want v=1 d=%0h", i, out_valid, out_dest, i - 1); end
      end
    end
    @(posedge clk); #1; idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_dest !== 4'h8) begin
      bad++; $display("FAIL stream_last: got v=%b d=%0h want v=1 d=8", out_valid, out_dest); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic fill_full();
    @(posedge clk); #1; out_ready = 1'b0; drive_item(4'h3, 32'hA3, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; drive_item(4'h5, 32'hA5, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_full();
    @(negedge clk);
    total++; if (out_dest !== 4'h3 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_half: got d=%0h r=%b want d=3 r=1", out_dest, in_ready); end
    @(posedge clk); #1; idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest !== 4'h3) begin
        bad++; $display("FAIL bp_full[%0d]: got r=%b v=%b d=%0h want r=0 v=1 d=3", k, in_ready, out_valid, out_dest); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_dest !== 4'h3) begin bad++; $display("FAIL bp_out_a: got %0h want 3", out_dest); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_dest !== 4'h5 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_out_b: got d=%0h r=%b want d=5 r=1", out_dest, in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    fill_full();
    @(posedge clk); #1; flush = 1'b1; drive_item(4'hF, 32'hFF, 32'hFF, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1; flush = 1'b0; idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_wb_en !== 1'b0) begin
      bad++; $display("FAIL flush_empty: got v=%b we=%b want 0 0", out_valid, out_wb_en); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
    @(posedge clk); #1; out_ready = 1'b1; drive_item(4'h9, 32'h99, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_dest !== 4'h9) begin
      bad++; $display("FAIL flush_new: got v=%b d=%0h want v=1 d=9", out_valid, out_dest); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_alone: got %b want 0", out_valid); end
  endtask

  task automatic test_freeze();
    @(posedge clk); #1; out_ready = 1'b0; drive_item(4'h7, 32'h77, 32'h70, 1'b1, 1'b0);
    @(posedge clk); #1; freeze = 1'b1; out_ready = 1'b1; drive_item(4'hA, 32'hAA, 32'hA0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_dest !== 4'h7 || out_alu_res !== 32'h77 || in_ready !== 1'b0) begin
        bad++; $display("FAIL freeze_hold[%0d]: got v=%b d=%0h alu=%0h r=%b want v=1 d=7 alu=77 r=0",
                        k, out_valid, out_dest, out_alu_res, in_ready); end
      @(posedge clk); #1;
    end
    freeze = 1'b0; idle();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_dest !== 4'h7) begin
      bad++; $display("FAIL freeze_release: got v=%b d=%0h want v=1 d=7", out_valid, out_dest); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL freeze_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_bubble();
    @(posedge clk); #1; idle(); in_wb_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (out_wb_en !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL bubble_we[%0d]: got we=%b v=%b want 0 0", k, out_wb_en, out_valid); end
      @(posedge clk); #1;
    end
    drive_item(4'h2, 32'h22, 32'hDEADBEEF, 1'b1, 1'b1);
    @(posedge clk); #1; idle();
    @(negedge clk);
    total++; if (out_mem_r !== 1'b1 || out_mem_res !== 32'hDEADBEEF || out_wb_en !== 1'b1) begin
      bad++; $display("FAIL bubble_load: got mr=%b mem=%h we=%b want 1 deadbeef 1", out_mem_r, out_mem_res, out_wb_en); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_wb_en !== 1'b0) begin bad++; $display("FAIL bubble_after: got %b want 0", out_wb_en); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int cyc  = 0;
    localparam int N = 24;
    @(posedge clk); #1;
    drive_item(ADDR_W'(sent), DATA_W'(32'h5000 + sent * 17), ~DATA_W'(32'h5000 + sent * 17), 1'(sent), 1'(sent >> 1));
    while ((sent < N || exp_q.size() != 0 || out_valid) && cyc < 500) begin
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < N && $urandom_range(0, 4) != 0)
        drive_item(ADDR_W'(sent), DATA_W'(32'h5000 + sent * 17), ~DATA_W'(32'h5000 + sent * 17), 1'(sent), 1'(sent >> 1));
      else
        idle();
    end
    idle(); out_ready = 1'b1;
    total++; if (cyc >= 500 || sent != N || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_complete: got sent=%0d left=%0d cyc=%0d want sent=%0d left=0 within 500", sent, exp_q.size(), cyc, N); end
  endtask

  task automatic test_reset_mid();
    fill_full();
    @(posedge clk); #1; idle();
    #2; rst = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_alu_res !== '0 || out_dest !== '0) begin
      bad++; $display("FAIL midrst_clear: got v=%b r=%b alu=%0h d=%0h want all 0", out_valid, in_ready, out_alu_res, out_dest); end
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_nothing_left: got %b want 0", out_valid); end
  endtask

`ifdef MEM_WB_STALL_CNT_EN
  task automatic test_stall_cnt();
    @(posedge clk); #1; rst = 1'b0; idle(); out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    total++; if (stall_cnt !== 2'd0) begin bad++; $display("FAIL stall_reset: got %0d want 0", stall_cnt); end
    @(posedge clk); #1; drive_item(4'hC, 32'hCC, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; idle();
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (stall_cnt !== 2'((k > 3) ? 3 : k)) begin
        bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", k, stall_cnt, (k > 3) ? 3 : k); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    total = 0; bad = 0; sb_total = 0; sb_bad = 0;
    in_wb_en = 1'b0; in_mem_r = 1'b0; in_alu_res = '0; in_mem_res = '0; in_dest = '0;
    in_valid = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_freeze();
    test_bubble();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_WB_STALL_CNT_EN
    test_stall_cnt();
`endif
    @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d items want 0", exp_q.size()); end
    total += sb_total;
    bad   += sb_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_wb_pipe_stage.md
Name: mem_wb_pipe_stage

Overview:
- Parametrised successor to the fixed MEM→WB stage register: a 2-entry elastic stage with valid/ready handshake, a skid slot, flush and global freeze.
- Carries the write-back payload (wb_en, mem_r, alu_res, mem_res, dest) from MEM to WB.
- Lets WB backpressure (e.g. register-file port conflict) without a combinational ready path back into MEM.

Parameters:
- DATA_W, 32, width of alu_res and mem_res (register-file word).
- ADDR_W, 4, width of dest (register-file address).
- CNT_W, 16, width of stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  global hold; no transfer on either side while high.
- flush  in  1  discard all held entries.
- in_valid  in  1  MEM offers payload.
- in_ready  out  1  stage can accept.
- in_wb_en  in  1  write-back enable.
- in_mem_r  in  1  load (select mem_res in WB).
- in_alu_res  in  DATA_W  ALU result.
- in_mem_res  in  DATA_W  memory read data.
- in_dest  in  ADDR_W  destination register.
- out_valid  out  1  WB payload valid.
- out_ready  in  1  WB consumes.
- out_wb_en  out  1  gated write enable.
- out_mem_r  out  1  load flag.
- out_alu_res  out  DATA_W  ALU result.
- out_mem_res  out  DATA_W  memory data.
- out_dest  out  ADDR_W  destination register.

Behaviour:
- Storage: main slot (drives outputs) and skid slot, each with a valid bit.
- States: EMPTY (no valid slots), HALF (main valid), FULL (main and skid valid).
- Handshake terms:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready & ~freeze.
- Output and ready equations:
  - in_ready = ~skid_v & ~freeze & ~flush & rst. It is a register-driven term only: no combinational path from out_ready.
  - out_valid = main_v.
  - out_wb_en = main_wb_en & main_v, so bubbles never write.
- State transitions:
  - EMPTY: acc → HALF (main ← in).
  - HALF:
    - acc & pop → HALF (main ← in).
    - acc & ~pop → FULL (skid ← in).
    - pop & ~acc → EMPTY.
  - FULL:
    - pop → HALF (main ← skid).
    - acc is impossible in this state.
- Latency and throughput: 1 cycle minimum; one item per cycle sustained when out_ready is held high.
- Ordering: strict FIFO; no item is dropped or duplicated.
- flush:
  - Highest priority.
  - At the next edge, both valid bits go to 0 and the state goes to EMPTY.
  - Input offered in the flush cycle is discarded.
  - Payload registers may keep stale data.
- freeze:
  - All state holds. out_* remain stable.
  - flush overrides freeze.
- Simultaneous flush and pop: WB may sample the item in that cycle; the stage still empties.
- Reset (rst=0, asynchronous):
  - Valid bits = 0, all payload registers = 0.
  - All out_* = 0 and in_ready = 0 while rst is asserted.
  - in_ready goes to 1 in the first cycle after release unless freeze or flush is high.
- Reset asserted mid-transfer: all contents are lost; no partial state survives.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- With the macro defined:
  - Extra output stall_cnt [CNT_W-1:0].
  - Increments on each cycle with out_valid & ~out_ready & ~freeze.
  - Saturates at all-ones.
  - Cleared only by rst.
- Without the macro: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - REG_DATA_W = 32 and REG_ADDR_W = 4 constants.
  - A packed wb_payload_t struct: wb_en, mem_r, alu_res, mem_res, dest.
- One sub-module, stage_slot:
  - Payload register with valid bit, load and clear inputs, async active-low reset.
  - Instantiated twice (main and skid).

Test Plan:
- Reset then stream: rst low for 3 cycles, then 8 items with dest=1..8 and alu_res=0x100+i, out_ready=1 → out_dest sequence 1..8, each 1 cycle after acceptance, in_ready held at 1.
- Backpressure: out_ready=0 after item A (dest 3) is held, offer B (dest 5) → B goes to skid, in_ready=0, out_dest stays 3. Then set out_ready=1 → outputs 3 then 5, in_ready back to 1.
- Flush while FULL: FULL with dest 3 and 5, assert flush for 1 cycle → next cycle out_valid=0 and out_wb_en=0; new item dest 9 accepted afterwards emerges alone.
- Freeze: main holds dest 7, freeze=1 for 4 cycles with in_valid=1 and out_ready=1 → outputs stable, in_ready=0, no items consumed or accepted.
- Bubble gating: in_wb_en=1 with in_valid=0 → out_wb_en stays 0. Load item with mem_r=1 and mem_res=0xDEADBEEF → out_mem_r=1 and out_mem_res=0xDEADBEEF.
- With MEM_WB_STALL_CNT_EN and CNT_W=2: hold out_valid=1 and out_ready=0 for 6 cycles → stall_cnt = 1, 2, 3, 3, 3, 3.
